hex_scroll_display: RTL

Drives the six DE10-Standard seven-segment displays (HEX5..HEX0) with a scrolling text message built from 4-bit character codes. An internal prescaler turns the 50 MHz board clock into a step tick. The tick advances a message pointer; the six displays show a sliding window of the message that wraps around. Sits between the board clock/switches and the HEX pins, one level above the single-digit segment-pattern stage.

---
 rtl/hex_disp_pkg.sv | 55 +++++
 rtl/hex7seg_decode.sv | 31 +++
 rtl/hex_scroll_display.sv | 102 ++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the seven-segment display path: segment bit order,
// active-low glyph patterns and 4-bit character codes.
package hex_disp_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned NUM_DIGITS = 6;

  // Segment bit positions within a pattern: bit0=a .. bit6=g, 0 = lit.
  localparam int unsigned SEG_BIT_A = 0;
  localparam int unsigned SEG_BIT_B = 1;
  localparam int unsigned SEG_BIT_C = 2;
  localparam int unsigned SEG_BIT_D = 3;
  localparam int unsigned SEG_BIT_E = 4;
  localparam int unsigned SEG_BIT_F = 5;
  localparam int unsigned SEG_BIT_G = 6;

  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [CODE_W-1:0] code_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam code_t CH_0     = 4'h0;
  localparam code_t CH_1     = 4'h1;
  localparam code_t CH_2     = 4'h2;
  localparam code_t CH_3     = 4'h3;
  localparam code_t CH_4     = 4'h4;
  localparam code_t CH_5     = 4'h5;
  localparam code_t CH_6     = 4'h6;
  localparam code_t CH_7     = 4'h7;
  localparam code_t CH_8     = 4'h8;
  localparam code_t CH_9     = 4'h9;
  localparam code_t CH_A     = 4'hA;
  localparam code_t CH_B     = 4'hB;
  localparam code_t CH_C     = 4'hC;
  localparam code_t CH_D     = 4'hD;
  localparam code_t CH_E     = 4'hE;
  localparam code_t CH_BLANK = 4'hF;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 4-bit character code to active-low seven-segment pattern.
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code)
      CH_0:     seg_c = SEG_0;
      CH_1:     seg_c = SEG_1;
      CH_2:     seg_c = SEG_2;
      CH_3:     seg_c = SEG_3;
      CH_4:     seg_c = SEG_4;
      CH_5:     seg_c = SEG_5;
      CH_6:     seg_c = SEG_6;
      CH_7:     seg_c = SEG_7;
      CH_8:     seg_c = SEG_8;
      CH_9:     seg_c = SEG_9;
      CH_A:     seg_c = SEG_A;
      CH_B:     seg_c = SEG_B;
      CH_C:     seg_c = SEG_C;
      CH_D:     seg_c = SEG_D;
      CH_E:     seg_c = SEG_E;
      default:  seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_display.sv
// Scrolls a fixed message of 4-bit character codes across HEX5..HEX0,
// advancing one character per prescaler step in the direction chosen by dir.
module hex_scroll_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned        STEP_DIV = 25000000,
  parameter int unsigned        MSG_LEN  = 8,
  parameter logic [4*MSG_LEN-1:0] MSG    = 32'hDE10_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             dir,
  output logic             step_tick,
  output logic [3:0]       pos,
  output logic [SEG_W-1:0] hex5,
  output logic [SEG_W-1:0] hex4,
  output logic [SEG_W-1:0] hex3,
  output logic [SEG_W-1:0] hex2,
  output logic [SEG_W-1:0] hex1,
  output logic [SEG_W-1:0] hex0
);

  localparam int unsigned CNT_W   = 26;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned MAX_LEN = 16;

  localparam logic [CNT_W-1:0] TERM     = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              term_c;
  logic [CODE_W-1:0] msg_chars [MAX_LEN];
  logic [SEG_W-1:0]  win_seg   [NUM_DIGITS];

  // Unpack the message; character 0 is the most-significant nibble.
  for (genvar c = 0; c < MAX_LEN; c++) begin : g_chars
    if (c < MSG_LEN) begin : g_used
      assign msg_chars[c] = MSG[(MSG_LEN-1-c)*CODE_W +: CODE_W];
    end else begin : g_unused
      assign msg_chars[c] = CH_BLANK;
    end
  end

  // Window slot k shows msg[(pos+k) mod MSG_LEN]; slot 0 drives hex5.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_win
    logic [POS_W-1:0] idx;

    assign idx = ({1'b0, pos} >= LEN_W'(MSG_LEN - k)) ? (pos - POS_W'(MSG_LEN - k))
                                                      : (pos + POS_W'(k));

    hex7seg_decode u_dec (
      .code  (msg_chars[idx]),
      .seg_c (win_seg[k])
    );
  end

  always_comb begin
    term_c    = run && (count == TERM);
    count_nxt = count;
    pos_nxt   = pos;
    if (term_c) begin
      count_nxt = '0;
      if (dir) begin
        pos_nxt = (pos == '0) ? POS_LAST : pos - POS_W'(1);
      end else begin
        pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
      end
    end else if (run) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // Display registers load from the current pointer, lagging it by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      pos       <= '0;
      step_tick <= 1'b0;
      hex5      <= SEG_BLANK;
      hex4      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex0      <= SEG_BLANK;
    end else begin
      count     <= count_nxt;
      pos       <= pos_nxt;
      step_tick <= term_c;
      hex5      <= win_seg[0];
      hex4      <= win_seg[1];
      hex3      <= win_seg[2];
      hex2      <= win_seg[3];
      hex1      <= win_seg[4];
      hex0      <= win_seg[5];
    end
  end

endmodule
